servo_pwm_multi: RTL and testbench
==================================

Name: servo_pwm_multi

Overview:
Multi-channel servo PWM generator; parametrised successor of the single-channel switch-driven servo PWM.
- One shared prescaler and frame counter drive N_CH independent pulse-width channels.
- Each channel maps a POS_W-bit position to a pulse width in the MIN_US..MAX_US range.
- Channel widths are double-buffered and change only on frame boundaries, with optional per-frame slew limiting.
- Sits between the board switch/host register logic and the servo header pins.

Parameters:
CLK_HZ, 50000000, system clock frequency
TICK_HZ, 1000000, frame-counter tick rate (1 us resolution); CLK_HZ/TICK_HZ must be an integer >= 2
N_CH, 4, number of servo channels (1..16)
POS_W, 10, position input width per channel
PERIOD_US, 20000, frame length in ticks
MIN_US, 500, pulse width at position 0
MAX_US, 2500, pulse width at position 2^POS_W-1; requires MIN_US < MAX_US < PERIOD_US
SLEW_US, 0, max width change per channel per frame in ticks; 0 = unlimited

Ports:
clk  in  1  system clock
rst_a  in  1  asynchronous active-low reset
enable  in  1  1 = drive outputs; 0 = force pwm_out low (counters keep running)
pos_in  in  N_CH*POS_W  packed positions; channel i is bits [i*POS_W +: POS_W]
pos_valid  in  N_CH  per-channel load strobe, one clk wide
pwm_out  out  N_CH  registered servo pulses
frame_start  out  1  one-clk pulse on the cycle the frame counter wraps to 0
width_dbg  out  N_CH*16  active width of each channel in ticks (zero-extended)

Behaviour:
- Reset (rst_a low, async):
  - prescaler = 0, frame counter = 0, pwm_out = 0, frame_start = 0.
  - Every shadow and active width = MID = (MIN_US+MAX_US)/2, integer floor.
- Prescaler:
  - Counts 0..DIV-1, where DIV = CLK_HZ/TICK_HZ.
  - tick is asserted for one clk when the count is DIV-1.
- Frame counter:
  - Advances on tick through 0..PERIOD_US-1.
  - Boundary = tick while the counter is PERIOD_US-1; the counter wraps to 0 on the next clk.
  - frame_start is registered high on that clk.
- Position load:
  - pos_valid[i] at cycle t -> shadow[i] = MIN_US + floor(pos_i*(MAX_US-MIN_US)/(2^POS_W-1)), valid at t+1.
  - Use a full-precision product (POS_W + clog2(MAX_US) bits); no truncation before the divide.
  - Divide by constant; combinational, one register stage.
  - A later pos_valid overwrites an earlier one within the same frame; the last value wins.
- Frame update (on boundary clk b):
  - active[i] takes the value shadow[i] holds at cycle b, so a pos_valid at t <= b-1 takes effect.
  - A pos_valid at b or later takes effect at the next boundary.
  - If SLEW_US > 0: active moves toward shadow by min(|shadow-active|, SLEW_US). There is no overshoot, and it reaches the target exactly.
  - Widths never change mid-frame, so there are no runt or stretched pulses.
- Output:
  - pwm_out[i] <= enable && (frame_cnt < active[i]), registered.
  - Pulse is high for exactly active[i] ticks starting at counter 0, with one clk latency after the counter.
  - enable deassert takes effect the next clk; reassert resumes mid-frame according to the compare.
- Simultaneous pos_valid on all channels is legal; channels are fully independent.
- Reset mid-frame: outputs drop immediately, and the first frame after release starts at counter 0 with MID widths.

Decomposition:
- Package servo_pkg:
  - clog2 function.
  - Localparams DIV, CNT_W = clog2(PERIOD_US), WID_W = clog2(MAX_US+1), MID.
  - Parameter sanity checks (elaboration-time assertions).
- One sub-module, servo_pwm_chan, generated N_CH times. It contains:
  - shadow and active registers;
  - scale arithmetic;
  - slew limiter;
  - output compare.
- Prescaler and frame counter stay in the top level.

Test Plan:
Bench parameters: CLK_HZ=4, TICK_HZ=1 (DIV=4), PERIOD_US=100, MIN_US=10, MAX_US=30, POS_W=4, N_CH=2. MID=20.
1. Reset release, enable=1, no loads -> both pwm_out high for 20 ticks (80 clk) of every 100-tick (400 clk) frame; frame_start every 400 clk.
2. Load pos 0 / 15 on ch0 / ch1 mid-frame -> current frame unchanged; next frame gives 10 / 30 ticks.
3. Load pos 7 -> width 19 ticks (floor 140/15). Load 3 then 12 in the same frame -> only 26 applied.
4. pos_valid one clk before boundary -> applied at that boundary. pos_valid on the boundary clk -> applied one frame later.
5. SLEW_US=4, load pos 15 from MID -> widths 24, 28, 30, 30 over successive frames. Then pos 0 -> 26, 22, 18, 14, 10.
6. enable low for 3 frames -> pwm_out=0 while frame_start keeps pulsing. Assert rst_a low mid-pulse -> pwm_out=0 immediately, widths back to 20.

Source files
------------

// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared helpers for the multi-channel servo PWM generator:
//   - slew_dir_e : direction of a per-frame width step
//   - clog2      : ceiling log2 for constant widths
//   - bits_for   : clog2 clamped to at least one bit
//   - calc_div   : prescaler divide ratio
//   - calc_mid   : reset / idle pulse width
//   - params_ok  : elaboration-time legality check of a parameter set
// -----------------------------------------------------------------------------
package servo_pkg;

    typedef enum logic [1:0] {
        SLEW_HOLD = 2'd0,
        SLEW_UP   = 2'd1,
        SLEW_DOWN = 2'd2
    } slew_dir_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((r < 31) && ((1 << r) < value)) begin
            r++;
        end
        return r;
    endfunction

    function automatic int bits_for(input int value);
        int r;
        r = clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int calc_mid(input int min_us, input int max_us);
        return (min_us + max_us) / 2;
    endfunction

    function automatic bit params_ok(input int clk_hz, input int tick_hz,
                                     input int n_ch, input int pos_w,
                                     input int period_us, input int min_us,
                                     input int max_us, input int slew_us);
        bit ok;
        ok = 1'b1;
        if (tick_hz <= 0 || clk_hz <= 0) begin
            ok = 1'b0;
        end else begin
            if ((clk_hz % tick_hz) != 0) ok = 1'b0;
            if ((clk_hz / tick_hz) < 2)  ok = 1'b0;
        end
        if (n_ch < 1 || n_ch > 16)          ok = 1'b0;
        if (pos_w < 1 || pos_w > 16)        ok = 1'b0;
        if (min_us < 0)                     ok = 1'b0;
        if (!(min_us < max_us))             ok = 1'b0;
        if (!(max_us < period_us))          ok = 1'b0;
        // width_dbg reports each width in a 16-bit field
        if (max_us > 65535)                 ok = 1'b0;
        if (slew_us < 0)                    ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// -----------------------------------------------------------------------------
// servo_pwm_chan
// One servo channel: position-to-width scaling, double-buffered width
// (shadow loaded on pos_valid_i, active loaded on the frame boundary),
// optional per-frame slew limit and the registered PWM compare.
//
// Ports
//   clk, rst_a        : clock, asynchronous active-low reset
//   enable_i          : 0 forces pwm_o low from the next clock
//   pos_i             : POS_W-bit position
//   pos_valid_i       : one-clock load strobe for pos_i
//   frame_update_i    : frame boundary strobe (tick at last count)
//   frame_cnt_i       : shared frame counter
//   pwm_o             : registered servo pulse
//   width_o           : active width in ticks
// -----------------------------------------------------------------------------
module servo_pwm_chan
    import servo_pkg::*;
#(
    parameter int POS_W   = 10,
    parameter int MIN_US  = 500,
    parameter int MAX_US  = 2500,
    parameter int SLEW_US = 0,
    parameter int CNT_W   = 15,
    parameter int WID_W   = 12
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             enable_i,
    input  logic [POS_W-1:0] pos_i,
    input  logic             pos_valid_i,
    input  logic             frame_update_i,
    input  logic [CNT_W-1:0] frame_cnt_i,
    output logic             pwm_o,
    output logic [WID_W-1:0] width_o
);

    localparam int SPAN     = MAX_US - MIN_US;
    localparam int POS_MAX  = (1 << POS_W) - 1;
    localparam int PROD_W   = POS_W + WID_W;
    localparam int MID      = calc_mid(MIN_US, MAX_US);
    localparam int SLEW_CAP = (SLEW_US > SPAN) ? SPAN : SLEW_US;
    localparam int CMP_W    = (CNT_W > WID_W) ? CNT_W : WID_W;

    logic [WID_W-1:0]  shadow_q, shadow_d;
    logic [WID_W-1:0]  active_q, active_d;
    logic              pwm_q, pwm_d;

    logic [PROD_W-1:0] prod;
    logic [WID_W-1:0]  scaled;
    logic [WID_W-1:0]  gap;
    logic [WID_W-1:0]  step;
    logic [WID_W-1:0]  active_next;
    slew_dir_e         dir;

    // Full-width product first so the floor happens only once, at the divide.
    assign prod   = PROD_W'(pos_i) * PROD_W'(SPAN);
    assign scaled = WID_W'(prod / PROD_W'(POS_MAX)) + WID_W'(MIN_US);

    always_comb begin
        shadow_d = pos_valid_i ? scaled : shadow_q;

        if (shadow_q > active_q) begin
            dir = SLEW_UP;
            gap = shadow_q - active_q;
        end else if (shadow_q < active_q) begin
            dir = SLEW_DOWN;
            gap = active_q - shadow_q;
        end else begin
            dir = SLEW_HOLD;
            gap = '0;
        end

        // Clamping the step to the remaining gap lands exactly on the target.
        step = gap;
        if ((SLEW_US > 0) && (gap > WID_W'(SLEW_CAP))) begin
            step = WID_W'(SLEW_CAP);
        end

        unique case (dir)
            SLEW_UP:   active_next = active_q + step;
            SLEW_DOWN: active_next = active_q - step;
            default:   active_next = active_q;
        endcase

        active_d = frame_update_i ? active_next : active_q;

        pwm_d = enable_i && (CMP_W'(frame_cnt_i) < CMP_W'(active_q));
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            shadow_q <= WID_W'(MID);
            active_q <= WID_W'(MID);
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign width_o = active_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// -----------------------------------------------------------------------------
// servo_pwm_multi
// Multi-channel servo PWM generator. A shared prescaler produces a tick every
// CLK_HZ/TICK_HZ clocks; a shared frame counter steps 0..PERIOD_US-1 on each
// tick. N_CH channels each compare the counter against their active width.
//
// Ports
//   clk          : system clock
//   rst_a        : asynchronous active-low reset
//   enable       : 1 drives outputs, 0 forces pwm_out low (counters run)
//   pos_in       : packed positions, channel i at [i*POS_W +: POS_W]
//   pos_valid    : per-channel one-clock load strobes
//   pwm_out      : registered servo pulses
//   frame_start  : one-clock pulse while the frame counter sits at 0 after a wrap
//   width_dbg    : active width per channel, 16 bits each, zero-extended
// -----------------------------------------------------------------------------
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 1000000,
    parameter int N_CH      = 4,
    parameter int POS_W     = 10,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 500,
    parameter int MAX_US    = 2500,
    parameter int SLEW_US   = 0
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  enable,
    input  logic [N_CH*POS_W-1:0] pos_in,
    input  logic [N_CH-1:0]       pos_valid,
    output logic [N_CH-1:0]       pwm_out,
    output logic                  frame_start,
    output logic [N_CH*16-1:0]    width_dbg
);

    localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int PRE_W = bits_for(DIV);
    localparam int CNT_W = bits_for(PERIOD_US);
    localparam int WID_W = bits_for(MAX_US + 1);

    if (!params_ok(CLK_HZ, TICK_HZ, N_CH, POS_W, PERIOD_US, MIN_US, MAX_US, SLEW_US))
    begin : g_bad_params
        $error("servo_pwm_multi: illegal parameter combination");
    end

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             frame_start_q;
    logic             tick;
    logic             boundary;

    assign tick     = (presc_q == PRE_W'(DIV - 1));
    assign boundary = tick && (frame_cnt_q == CNT_W'(PERIOD_US - 1));

    always_comb begin
        presc_d     = tick ? '0 : presc_q + PRE_W'(1);
        frame_cnt_d = frame_cnt_q;
        if (boundary) begin
            frame_cnt_d = '0;
        end else if (tick) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            presc_q       <= '0;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= boundary;
        end
    end

    assign frame_start = frame_start_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        logic [WID_W-1:0] width;

        servo_pwm_chan #(
            .POS_W   (POS_W),
            .MIN_US  (MIN_US),
            .MAX_US  (MAX_US),
            .SLEW_US (SLEW_US),
            .CNT_W   (CNT_W),
            .WID_W   (WID_W)
        ) u_chan (
            .clk            (clk),
            .rst_a          (rst_a),
            .enable_i       (enable),
            .pos_i          (pos_in[i*POS_W +: POS_W]),
            .pos_valid_i    (pos_valid[i]),
            .frame_update_i (boundary),
            .frame_cnt_i    (frame_cnt_q),
            .pwm_o          (pwm_out[i]),
            .width_o        (width)
        );

        assign width_dbg[i*16 +: 16] = 16'(width);
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Two instances share clock, reset and enable: u_dut without slew limiting,
// u_dut_s with SLEW_US=4. Channels are numbered 0,1 (u_dut) and 2,3 (u_dut_s).
// For every frame the stimulus pushes the widths expected at its frame_start
// and the pwm high-clock count expected over that frame; the monitor checks
// both whenever frame_start is seen.
module tb_servo_pwm_multi;

    localparam int N_CH  = 2;
    localparam int POS_W = 4;
    localparam int DIV   = 4;
    localparam int FRAME = 400;

    typedef struct packed {
        logic [3:0][15:0] w;
        logic [3:0][15:0] c;
    } rec_t;

    logic                  clk = 1'b0;
    logic                  rst_a = 1'b0;
    logic                  enable = 1'b0;
    logic [N_CH*POS_W-1:0] pos_in = '0;
    logic [N_CH*POS_W-1:0] pos_in_s = '0;
    logic [N_CH-1:0]       pos_valid = '0;
    logic [N_CH-1:0]       pos_valid_s = '0;
    logic [N_CH-1:0]       pwm_out, pwm_out_s;
    logic                  frame_start, frame_start_s;
    logic [N_CH*16-1:0]    width_dbg, width_dbg_s;

    logic [3:0]            pwm_all;
    logic [63:0]           width_all;

    assign pwm_all   = {pwm_out_s, pwm_out};
    assign width_all = {width_dbg_s, width_dbg};

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .CLK_HZ(4), .TICK_HZ(1), .N_CH(N_CH), .POS_W(POS_W), .PERIOD_US(100),
        .MIN_US(10), .MAX_US(30), .SLEW_US(0)
    ) u_dut (
        .clk(clk), .rst_a(rst_a), .enable(enable), .pos_in(pos_in),
        .pos_valid(pos_valid), .pwm_out(pwm_out), .frame_start(frame_start),
        .width_dbg(width_dbg)
    );

    servo_pwm_multi #(
        .CLK_HZ(4), .TICK_HZ(1), .N_CH(N_CH), .POS_W(POS_W), .PERIOD_US(100),
        .MIN_US(10), .MAX_US(30), .SLEW_US(4)
    ) u_dut_s (
        .clk(clk), .rst_a(rst_a), .enable(enable), .pos_in(pos_in_s),
        .pos_valid(pos_valid_s), .pwm_out(pwm_out_s), .frame_start(frame_start_s),
        .width_dbg(width_dbg_s)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // mode 0: enabled all frame, 1: disabled all frame,
    // 2: enable reasserted 40 clocks into the frame
    task automatic push(input int w0, input int w1, input int s0, input int s1,
                        input int mode);
        rec_t r;
        int   w[4];
        int   c;
        w = '{w0, w1, s0, s1};
        for (int k = 0; k < 4; k++) begin
            case (mode)
                0:       c = DIV * w[k];
                1:       c = 0;
                default: c = (DIV * w[k] > 40) ? DIV * w[k] - 40 : 0;
            endcase
            r.w[k] = 16'(w[k]);
            r.c[k] = 16'(c);
        end
        exp_q.push_back(r);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n = i + 1;
            if (frame_start) return;
        end
        chk("frame_start_timeout", 0, 1);
    endtask

    task automatic pulse(input bit slew, input logic [1:0] mask,
                         input int p0, input int p1);
        logic [3:0] v0, v1;
        v0 = 4'(p0);
        v1 = 4'(p1);
        if (slew) begin
            if (mask[0]) pos_in_s[3:0] = v0;
            if (mask[1]) pos_in_s[7:4] = v1;
            pos_valid_s = mask;
        end else begin
            if (mask[0]) pos_in[3:0] = v0;
            if (mask[1]) pos_in[7:4] = v1;
            pos_valid = mask;
        end
        @(negedge clk);
        pos_valid   = '0;
        pos_valid_s = '0;
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        rec_t prev;
        rec_t cur;
        bit   have_prev;
        int   hi[4];
        int   gap;
        int   fidx;
        have_prev = 1'b0;
        gap  = 0;
        fidx = 0;
        prev = '0;
        hi   = '{0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                have_prev = 1'b0;
                gap = 0;
                hi  = '{0, 0, 0, 0};
            end else begin
                gap++;
                if (frame_start) begin
                    fidx++;
                    chk($sformatf("f%0d_fs_pair", fidx), int'(frame_start_s), 1);
                    if (have_prev) begin
                        chk($sformatf("f%0d_gap", fidx), gap, FRAME);
                        for (int k = 0; k < 4; k++)
                            chk($sformatf("f%0d_prev_hi%0d", fidx, k), hi[k], int'(prev.c[k]));
                    end
                    if (exp_q.size() == 0) begin
                        chk($sformatf("f%0d_unexpected_frame", fidx), 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        for (int k = 0; k < 4; k++)
                            chk($sformatf("f%0d_w%0d", fidx, k),
                                int'(width_all[k*16 +: 16]), int'(cur.w[k]));
                        prev = cur;
                        have_prev = 1'b1;
                    end
                    gap = 0;
                    hi  = '{0, 0, 0, 0};
                end
                for (int k = 0; k < 4; k++) hi[k] += int'(pwm_all[k]);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin : stim
        int n;
        rst_a  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rst_w%0d", k), int'(width_all[k*16 +: 16]), 20);
        chk("rst_pwm", int'(pwm_all), 0);
        chk("rst_fs", int'(frame_start), 0);

        // 1: idle MID widths
        push(20, 20, 20, 20, 0);
        rst_a = 1'b1;
        wait_fs(n);
        chk("first_frame_len", n, FRAME);
        push(20, 20, 20, 20, 0);
        wait_fs(n);

        // 2: mid-frame load, applied next frame
        push(10, 30, 20, 20, 0);
        repeat (100) @(negedge clk);
        pulse(1'b0, 2'b11, 0, 15);
        wait_fs(n);

        // 3: pos 7 -> 19; pos 3 then 12 in one frame -> 26
        push(19, 26, 20, 20, 0);
        repeat (50) @(negedge clk);
        pulse(1'b0, 2'b11, 7, 3);
        repeat (50) @(negedge clk);
        pulse(1'b0, 2'b10, 0, 12);
        wait_fs(n);

        // 4: load at boundary-1 (ch0) and at boundary (ch1)
        push(30, 26, 20, 20, 0);
        push(30, 10, 20, 20, 0);
        repeat (398) @(negedge clk);
        pos_in[3:0] = 4'd15;
        pos_valid   = 2'b01;
        @(negedge clk);
        pos_in[7:4] = 4'd0;
        pos_valid   = 2'b10;
        wait_fs(n);
        pos_valid = '0;
        wait_fs(n);

        // 5: slew-limited channels
        push(30, 10, 24, 16, 0);
        pulse(1'b1, 2'b11, 15, 0);
        wait_fs(n);
        push(30, 10, 28, 12, 0);
        wait_fs(n);
        push(30, 10, 30, 10, 0);
        wait_fs(n);
        push(30, 10, 30, 10, 0);
        wait_fs(n);
        push(30, 10, 26, 14, 0);
        pulse(1'b1, 2'b11, 0, 15);
        wait_fs(n);
        push(30, 10, 22, 18, 0);
        wait_fs(n);
        push(30, 10, 18, 22, 0);
        wait_fs(n);
        push(30, 10, 14, 26, 0);
        wait_fs(n);
        push(30, 10, 10, 30, 0);
        wait_fs(n);

        // 6: enable low for three frames, then mid-frame reassert
        push(30, 10, 10, 30, 1);
        wait_fs(n);
        enable = 1'b0;
        push(30, 10, 10, 30, 1);
        wait_fs(n);
        push(30, 10, 10, 30, 1);
        wait_fs(n);
        push(30, 10, 10, 30, 2);
        wait_fs(n);
        repeat (40) @(negedge clk);
        enable = 1'b1;
        push(30, 10, 10, 30, 0);
        wait_fs(n);

        // reset in the middle of the pulse
        repeat (20) @(negedge clk);
        chk("pre_rst_pwm", int'(pwm_all), 15);
        rst_a = 1'b0;
        #1;
        chk("mid_rst_pwm", int'(pwm_all), 0);
        chk("mid_rst_fs", int'(frame_start), 0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("mid_rst_w%0d", k), int'(width_all[k*16 +: 16]), 20);
        exp_q.delete();
        push(20, 20, 20, 20, 0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        wait_fs(n);
        chk("post_rst_frame_len", n, FRAME);
        push(20, 20, 20, 20, 0);
        wait_fs(n);

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
